// File: rtl/fir_capture_if.sv
// rtl/fir_capture_if.sv - control, sample and readout signals of the FIR capture buffer
interface fir_capture_if #(
  parameter int DATA_BITS = 20
);
  logic                 start;
  logic                 abort;
  logic [DATA_BITS-1:0] data_in;
  logic                 rd_ready;
  logic                 rd_valid;
  logic [DATA_BITS-1:0] rd_data;
  logic                 busy;
  logic                 done;

  modport master (
    output start, abort, data_in, rd_ready,
    input  rd_valid, rd_data, busy, done
  );

  modport slave (
    input  start, abort, data_in, rd_ready,
    output rd_valid, rd_data, busy, done
  );
endinterface

// File: rtl/fir_capture.sv
// rtl/fir_capture.sv - discards SKIP settling samples, stores DEPTH FIR samples, streams them out
module fir_capture #(
  parameter int DATA_BITS = 20,
  parameter int DEPTH     = 64,
  parameter int SKIP      = 63
) (
  input  logic        clk,
  input  logic        rst,
  fir_capture_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CAPTURE, S_READ} state_t;

  localparam int               PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [9:0]       SKIP_LAST = (SKIP > 0) ? 10'(SKIP - 1) : 10'd0;

  state_t               state;
  state_t               state_next;
  logic [9:0]           skip_cnt;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 rd_valid_q;
  logic [DATA_BITS-1:0] rd_data_q;
  logic                 done_q;
  logic [DATA_BITS-1:0] mem [DEPTH];

  logic clr_ptrs;
  logic skip_en;
  logic wr_en;
  logic load_first;
  logic advance;
  logic finish;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // abort overrides every transition and every datapath strobe
  always_comb begin
    state_next = state;
    clr_ptrs   = 1'b0;
    skip_en    = 1'b0;
    wr_en      = 1'b0;
    load_first = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    if (bus.abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            clr_ptrs   = 1'b1;
            state_next = (SKIP > 0) ? S_SKIP : S_CAPTURE;
          end
        end
        S_SKIP: begin
          skip_en = 1'b1;
          if (skip_cnt == SKIP_LAST) begin
            state_next = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          wr_en = 1'b1;
          if (wr_ptr == LAST_PTR) begin
            load_first = 1'b1;
            state_next = S_READ;
          end
        end
        S_READ: begin
          if (rd_valid_q && bus.rd_ready) begin
            if (rd_ptr == LAST_PTR) begin
              finish     = 1'b1;
              state_next = S_IDLE;
            end else begin
              advance = 1'b1;
            end
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= finish;
      if (bus.abort || finish) begin
        rd_valid_q <= 1'b0;
      end
      if (clr_ptrs) begin
        skip_cnt <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end
      if (skip_en) begin
        skip_cnt <= skip_cnt + 10'd1;
      end
      if (wr_en && (wr_ptr != LAST_PTR)) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      // mem[0] was written at least one cycle before the final capture edge
      if (load_first) begin
        rd_data_q  <= mem[0];
        rd_valid_q <= 1'b1;
        rd_ptr     <= '0;
      end
      if (advance) begin
        rd_ptr    <= rd_ptr + 1'b1;
        rd_data_q <= mem[rd_ptr + 1'b1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_fir_capture.sv
// tb/tb_fir_capture.sv - scoreboard bench for fir_capture in two parameter sets
module tb_fir_capture;
  localparam int DB = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_capture_if #(.DATA_BITS(DB)) ifa ();
  fir_capture_if #(.DATA_BITS(DB)) ifb ();

  fir_capture #(.DATA_BITS(DB), .DEPTH(8), .SKIP(3)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  fir_capture #(.DATA_BITS(DB), .DEPTH(4), .SKIP(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int vectors = 0;
  int miscompares = 0;
  int q_a[$];
  int q_b[$];
  int done_a = 0;
  int done_b = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.done) done_a++;
      if (ifa.rd_valid) begin
        if (q_a.size() == 0) check("a_unexpected_valid", 1, 0);
        else begin
          check("a_rd_data", int'($signed(ifa.rd_data)), q_a[0]);
          if (ifa.rd_ready) void'(q_a.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (ifb.done) done_b++;
      if (ifb.rd_valid) begin
        if (q_b.size() == 0) check("b_unexpected_valid", 1, 0);
        else begin
          check("b_rd_data", int'($signed(ifb.rd_data)), q_b[0]);
          if (ifb.rd_ready) void'(q_b.pop_front());
        end
      end
    end
  end

  // data_in = base+k on the k-th cycle after the start edge; samples base+3..base+10 are kept
  task automatic run_a(input int base, input bit toggle, input int restart_at, input int abort_at);
    int d0 = done_a;
    bit seen = 1'b0;
    bit [3:0] pat = 4'b1001;
    for (int i = 3; i < 11; i++) q_a.push_back(base + i);
    @(posedge clk); #1;
    ifa.start = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (done_a != d0) begin
        seen = 1'b1;
        break;
      end
      ifa.start    = (k == restart_at);
      ifa.abort    = (k == abort_at);
      ifa.data_in  = DB'(base + k);
      ifa.rd_ready = (k == abort_at) ? 1'b0 : (toggle ? pat[k % 4] : 1'b1);
      if (k == abort_at) begin
        @(posedge clk); #1;
        ifa.abort    = 1'b0;
        ifa.rd_ready = 1'b1;
        @(negedge clk);
        check("a_abort_busy", int'(ifa.busy), 0);
        check("a_abort_valid", int'(ifa.rd_valid), 0);
        q_a.delete();
        repeat (4) @(posedge clk);
        check("a_abort_no_done", done_a, d0);
        return;
      end
    end
    ifa.start    = 1'b0;
    ifa.rd_ready = 1'b1;
    check("a_done_seen", int'(seen), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_done_once", done_a, d0 + 1);
    check("a_all_read", q_a.size(), 0);
    check("a_idle_busy", int'(ifa.busy), 0);
  endtask

  task automatic run_b();
    int vals[4] = '{-512, 511, 0, -1};
    int d0 = done_b;
    bit seen = 1'b0;
    for (int i = 0; i < 4; i++) q_b.push_back(vals[i]);
    @(posedge clk); #1;
    ifb.start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done_b != d0) begin
        seen = 1'b1;
        break;
      end
      ifb.start   = 1'b0;
      ifb.data_in = (k < 4) ? DB'(vals[k]) : '0;
    end
    check("b_done_seen", int'(seen), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("b_done_once", done_b, d0 + 1);
    check("b_all_read", q_b.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ifa.start = 1'b0; ifa.abort = 1'b0; ifa.data_in = '0; ifa.rd_ready = 1'b1;
    ifb.start = 1'b0; ifb.abort = 1'b0; ifb.data_in = '0; ifb.rd_ready = 1'b1;
    #3;
    check("rst_a_busy", int'(ifa.busy), 0);
    check("rst_a_valid", int'(ifa.rd_valid), 0);
    check("rst_a_done", int'(ifa.done), 0);
    check("rst_a_data", int'(ifa.rd_data), 0);
    check("rst_b_busy", int'(ifb.busy), 0);
    check("rst_b_data", int'(ifb.rd_data), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_a(0, 1'b0, -1, -1);
    run_b();
    run_a(1000, 1'b1, -1, -1);
    run_a(2000, 1'b0, 5, -1);

    // abort in the same cycle as start
    @(posedge clk); #1;
    ifa.start = 1'b1; ifa.abort = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0; ifa.abort = 1'b0;
    @(negedge clk);
    check("a_start_abort_busy", int'(ifa.busy), 0);
    check("a_start_abort_valid", int'(ifa.rd_valid), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_start_abort_still_idle", int'(ifa.busy), 0);

    run_a(3000, 1'b0, -1, 13);

    // asynchronous reset between edges while capturing
    @(posedge clk); #1;
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_busy", int'(ifa.busy), 0);
    check("async_rst_valid", int'(ifa.rd_valid), 0);
    check("async_rst_done", int'(ifa.done), 0);
    check("async_rst_data", int'(ifa.rd_data), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q_a.delete();
    run_a(4000, 1'b0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
